// File: rtl/combo_lock_seq.sv
// combo_lock_seq: parametrised sequential combination lock.
// A SEQ_LEN-digit code is entered one CODE_W-bit digit per enter strobe,
// most significant digit first. Consecutive failures lead to a timed lockout.
// Optional feature macro: COMBO_LOCK_PROG_EN (re-program combination while open).
module combo_lock_seq #(
  parameter int CODE_W = 4,
  parameter int SEQ_LEN = 4,
  parameter logic [CODE_W*SEQ_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int OPEN_CYC = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CODE_W-1:0]            code,
  input  logic                         enter,
  input  logic                         prog,
  output logic                         unlocked,
  output logic                         error,
  output logic                         locked_out,
  output logic                         prog_mode,
  output logic [$clog2(SEQ_LEN+1)-1:0] digit_cnt
);

  localparam int CNT_W = $clog2(SEQ_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(SEQ_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_t;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt_n;
  logic                      mismatch, mismatch_n;
  logic [FAIL_W-1:0]         fail_cnt, fail_n, fail_inc;
  logic [TMR_W-1:0]          timer, timer_n;
  logic [CODE_W-1:0]         exp_digit;
  logic [CODE_W*SEQ_LEN-1:0] combo;

`ifdef COMBO_LOCK_PROG_EN
  logic [CODE_W*SEQ_LEN-1:0] combo_n;
`else
  logic unused_prog;
  assign unused_prog = prog;
  assign combo = DEFAULT_CODE;
`endif

  // Next-state and datapath updates; timers count down from N-1 and exit at 0
  always_comb begin
    state_n    = state;
    cnt_n      = digit_cnt;
    mismatch_n = mismatch;
    fail_n     = fail_cnt;
    timer_n    = timer;
    exp_digit  = '0;
    fail_inc   = (fail_cnt >= FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;
`ifdef COMBO_LOCK_PROG_EN
    combo_n    = combo;
`endif
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (digit_cnt == CNT_W'(i)) begin
        exp_digit = combo[(SEQ_LEN-1-i)*CODE_W +: CODE_W];
      end
    end
    case (state)
      ST_IDLE: begin
        if (enter) begin
          if (digit_cnt == LAST_DIGIT) begin
            cnt_n      = '0;
            mismatch_n = 1'b0;
            if (mismatch || (code != exp_digit)) begin
              state_n = ST_FAIL;
            end else begin
              state_n = ST_OPEN;
              timer_n = OPEN_LOAD;
              fail_n  = '0;
            end
          end else begin
            cnt_n      = digit_cnt + 1'b1;
            mismatch_n = mismatch | (code != exp_digit);
          end
        end
      end
      ST_OPEN: begin
`ifdef COMBO_LOCK_PROG_EN
        if (prog) begin
          state_n = ST_PROG;
          cnt_n   = '0;
        end else if (timer == '0) begin
          state_n = ST_IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
`else
        if (timer == '0) begin
          state_n = ST_IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
`endif
      end
      ST_FAIL: begin
        fail_n = fail_inc;
        if (fail_inc == FAIL_LIMIT) begin
          state_n = ST_LOCKOUT;
          timer_n = LOCK_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_n = ST_IDLE;
          fail_n  = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      ST_PROG: begin
`ifdef COMBO_LOCK_PROG_EN
        if (enter) begin
          for (int i = 0; i < SEQ_LEN; i++) begin
            if (digit_cnt == CNT_W'(i)) begin
              combo_n[(SEQ_LEN-1-i)*CODE_W +: CODE_W] = code;
            end
          end
          if (digit_cnt == LAST_DIGIT) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = digit_cnt + 1'b1;
          end
        end
`else
        state_n = ST_IDLE;
`endif
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset also restores the default combination
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      digit_cnt  <= '0;
      mismatch   <= 1'b0;
      fail_cnt   <= '0;
      timer      <= '0;
      unlocked   <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
      prog_mode  <= 1'b0;
    end else begin
      state      <= state_n;
      digit_cnt  <= cnt_n;
      mismatch   <= mismatch_n;
      fail_cnt   <= fail_n;
      timer      <= timer_n;
      unlocked   <= (state_n == ST_OPEN);
      error      <= (state_n == ST_FAIL);
      locked_out <= (state_n == ST_LOCKOUT);
      prog_mode  <= (state_n == ST_PROG);
    end
  end

`ifdef COMBO_LOCK_PROG_EN
  // Programmable combination storage
  always_ff @(posedge CLK) begin
    if (RST) begin
      combo <= DEFAULT_CODE;
    end else begin
      combo <= combo_n;
    end
  end
`endif

endmodule

// File: tb/tb_combo_lock_seq.sv
// tb_combo_lock_seq: directed scenarios plus randomized traffic for combo_lock_seq,
// checked every cycle against a behavioural model of the lock.
module tb_combo_lock_seq;

  localparam int SEQ = 4;
  localparam int MAXT = 3;
  localparam int OPENC = 8;
  localparam int LOCKC = 16;
`ifdef COMBO_LOCK_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic [3:0] code;
  logic       enter;
  logic       prog;
  logic       unlocked;
  logic       error;
  logic       locked_out;
  logic       prog_mode;
  logic [2:0] digit_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state
  int q[$];
  int combo_m[SEQ];
  int open_left = 0;
  int lock_left = 0;
  int fails = 0;
  bit err_now = 1'b0;
  bit prog_active = 1'b0;

  combo_lock_seq dut (
    .CLK(CLK), .RST(RST), .code(code), .enter(enter), .prog(prog),
    .unlocked(unlocked), .error(error), .locked_out(locked_out),
    .prog_mode(prog_mode), .digit_cnt(digit_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int d, input bit e, input bit p, input bit r);
    @(negedge CLK);
    #1;
    code  = 4'(d);
    enter = e;
    prog  = p;
    RST   = r;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enterSeq(input int a, input int b, input int c, input int d);
    applyStimulus(a, 1'b1, 1'b0, 1'b0);
    applyStimulus(b, 1'b1, 1'b0, 1'b0);
    applyStimulus(c, 1'b1, 1'b0, 1'b0);
    applyStimulus(d, 1'b1, 1'b0, 1'b0);
  endtask

  // Behavioural model of one clock edge, described in terms of the lock's rules
  task automatic modelStep();
    bit match;
    if (RST) begin
      q.delete();
      open_left = 0; lock_left = 0; fails = 0;
      err_now = 1'b0; prog_active = 1'b0;
      combo_m = '{1, 2, 3, 4};
    end else if (prog_active) begin
      if (enter) begin
        q.push_back(int'(code));
        if (q.size() == SEQ) begin
          for (int i = 0; i < SEQ; i++) combo_m[i] = q[i];
          q.delete();
          prog_active = 1'b0;
        end
      end
    end else if (open_left > 0) begin
      if (PROG_EN && prog) begin
        prog_active = 1'b1;
        open_left = 0;
      end else begin
        open_left--;
      end
    end else if (err_now) begin
      err_now = 1'b0;
      if (fails >= MAXT) begin
        lock_left = LOCKC;
        fails = 0;
      end
    end else if (lock_left > 0) begin
      lock_left--;
    end else if (enter) begin
      q.push_back(int'(code));
      if (q.size() == SEQ) begin
        match = 1'b1;
        for (int i = 0; i < SEQ; i++) if (q[i] != combo_m[i]) match = 1'b0;
        if (match) begin
          open_left = OPENC;
          fails = 0;
        end else begin
          err_now = 1'b1;
          fails++;
        end
        q.delete();
      end
    end
  endtask

  // Model advances on each rising edge
  initial begin
    combo_m = '{1, 2, 3, 4};
    forever begin
      @(posedge CLK);
      modelStep();
    end
  end

  // Compare DUT against model on every falling edge once out of the first reset
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        checkOutput("unlocked", int'(unlocked), int'(open_left > 0));
        checkOutput("error", int'(error), int'(err_now));
        checkOutput("locked_out", int'(locked_out), int'(lock_left > 0));
        checkOutput("prog_mode", int'(prog_mode), int'(prog_active));
        checkOutput("digit_cnt", int'(digit_cnt), q.size());
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int n;
    int d;
    RST = 1'b1; enter = 1'b0; prog = 1'b0; code = 4'd0;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    checkOutput("rst_unlocked", int'(unlocked), 0);
    checkOutput("rst_error", int'(error), 0);
    checkOutput("rst_locked_out", int'(locked_out), 0);
    checkOutput("rst_prog_mode", int'(prog_mode), 0);
    checkOutput("rst_digit_cnt", int'(digit_cnt), 0);
    idle(1);

    $display("[TB] scenario: correct code opens for 8 cycles");
    enterSeq(1, 2, 3, 4);
    idle(1);
    checkOutput("t1_open", int'(unlocked), 1);
    n = 1;
    repeat (11) begin
      idle(1);
      if (unlocked) n++;
    end
    checkOutput("t1_open_len", n, 8);

    $display("[TB] scenario: wrong last digit");
    enterSeq(1, 2, 3, 5);
    idle(1);
    checkOutput("t2_error", int'(error), 1);
    checkOutput("t2_unlocked", int'(unlocked), 0);
    idle(1);
    checkOutput("t2_error_pulse", int'(error), 0);

    $display("[TB] scenario: lockout after three failures");
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    idle(1);
    enterSeq(5, 5, 5, 5); idle(1);
    enterSeq(1, 2, 4, 4); idle(1);
    enterSeq(2, 2, 3, 4);
    idle(1);
    checkOutput("t3_error", int'(error), 1);
    idle(1);
    checkOutput("t3_locked", int'(locked_out), 1);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus((k < 10) ? (k % 4) + 1 : 0, k < 10, 1'b0, 1'b0);
      if (locked_out) n++;
    end
    checkOutput("t3_lock_len", n, 16);
    enterSeq(1, 2, 3, 4);
    idle(1);
    checkOutput("t3_open_after", int'(unlocked), 1);
    idle(10);

    $display("[TB] scenario: reset mid-sequence");
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(3, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_cnt_reset", int'(digit_cnt), 0);
    applyStimulus(4, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 1'b0);
    idle(1);
    checkOutput("t4_error", int'(error), 1);
    checkOutput("t4_unlocked", int'(unlocked), 0);
    idle(2);

`ifdef COMBO_LOCK_PROG_EN
    $display("[TB] scenario: program new combination");
    enterSeq(1, 2, 3, 4);
    applyStimulus(5, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_prog_mode", int'(prog_mode), 1);
    checkOutput("t5_prog_cnt", int'(digit_cnt), 0);
    enterSeq(9, 8, 7, 6);
    idle(1);
    checkOutput("t5_prog_done", int'(prog_mode), 0);
    enterSeq(1, 2, 3, 4);
    idle(1);
    checkOutput("t5_old_error", int'(error), 1);
    idle(1);
    enterSeq(9, 8, 7, 6);
    idle(1);
    checkOutput("t5_new_open", int'(unlocked), 1);
    idle(10);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    idle(1);
    enterSeq(1, 2, 3, 4);
    idle(1);
    checkOutput("t6_default_open", int'(unlocked), 1);
    idle(10);
`endif

    $display("[TB] scenario: randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      #1;
      if ($urandom_range(0, 3) != 0 && q.size() < SEQ && !prog_active)
        d = combo_m[q.size()];
      else
        d = int'($urandom_range(0, 15));
      code  = 4'(d);
      enter = ($urandom_range(0, 1) == 1);
      prog  = ($urandom_range(0, 7) == 0);
      RST   = ($urandom_range(0, 199) == 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
